rst_window_checker: RTL and testbench
=====================================

Name: rst_window_checker

Overview:
- Synthesisable, multi-channel checker for reset-release timing.
- Each channel is armed by a start pulse. It then verifies that its monitored reset deasserts no earlier than MIN_CYC and no later than MAX_CYC rising clock edges after arming.
- The bounded window is the RTL counterpart of the "eventually [2:3] !rst" property, generalised to N channels, a parametrised window, per-channel verdicts, measured latency and a global error counter.
- Sits beside reset generators and reset sequencers as an always-on, in-silicon checker.

Parameters:
- NCH, 4: number of independent channels.
- MIN_CYC, 2: earliest legal deassert edge after arming; must be >= 1.
- MAX_CYC, 3: latest legal deassert edge after arming; must be >= MIN_CYC. Illegal values are rejected by elaboration-time check.
- CW, $clog2(MAX_CYC+1): width of each per-channel latency field.
- AUTO_REARM, 0: 0 = verdicts are sticky until clear; 1 = verdict is a one-cycle pulse, then the channel returns to IDLE.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  NCH  per-channel arm request, sampled at the rising edge.
- clear  in  NCH  per-channel verdict clear / abort.
- mon_rst  in  NCH  monitored resets, active-high; deassert means 0.
- busy  out  NCH  channel is in WAIT.
- done  out  NCH  channel holds (or pulses) a verdict.
- pass  out  NCH  deassert landed inside the window.
- fail_early  out  NCH  deassert occurred before MIN_CYC.
- fail_late  out  NCH  no deassert by MAX_CYC.
- lat  out  NCH*CW  edge index k of the verdict; channel i occupies bits [i*CW +: CW].
- err_cnt  out  ERR_W  saturating count of fail verdicts, all channels.
- err_any  out  1  OR of fail_early|fail_late across channels.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All channels go to IDLE; cnt=0.
  - busy, done, pass, fail_early, fail_late, lat, err_cnt and err_any are all 0.
  - Reset asserted mid-WAIT aborts the check silently; no verdict and no error count.
- Per-channel FSM, states IDLE, WAIT, PASS, FAIL:
  - IDLE: at an edge with start[i]=1 and clear[i]=0, go to WAIT with cnt=0. The arming edge is edge 0.
  - WAIT: at each subsequent edge k=cnt+1, set cnt<=k, then evaluate mon_rst[i] sampled at that edge, in this order:
    - mon_rst=0 and k<MIN_CYC: go to FAIL, set fail_early, lat=k.
    - mon_rst=0 and MIN_CYC<=k<=MAX_CYC: go to PASS, lat=k.
    - mon_rst=1 and k==MAX_CYC: go to FAIL, set fail_late, lat=MAX_CYC.
    - Otherwise remain in WAIT.
  - Verdict latency: the outputs are registered and visible immediately after edge k.
  - PASS/FAIL with AUTO_REARM=0: hold done and the verdict flags until an edge with clear[i]=1, then go to IDLE with flags and lat cleared. start is ignored in these states.
  - PASS/FAIL with AUTO_REARM=1: done and the flag are high for exactly one cycle, then IDLE. lat retains its value until the next arm.
- Boundary conditions:
  - start while in WAIT is ignored; the window is not restarted.
  - clear in WAIT aborts to IDLE with no verdict.
  - clear and start on the same edge: clear wins. The channel goes to IDLE and arms on a later start.
  - mon_rst already 0 at the arming edge is not evaluated; only edges k>=1 count.
  - MIN_CYC==MAX_CYC gives a single legal edge.
- Error counter:
  - err_cnt adds the popcount of channels entering FAIL on that edge.
  - It saturates at 2^ERR_W-1 with no wrap.
  - It clears only on rst_n.
- err_any is combinational from the registered flags. In AUTO_REARM=1 it pulses with the flags.

Test Plan (MIN_CYC=2, MAX_CYC=3, NCH=4, AUTO_REARM=0 unless stated):
- ch0 start at edge 0, mon_rst[0] falls before edge 2 -> pass[0]=1, lat[0]=2, err_cnt=0, busy[0]=0 after edge 2.
- ch1 start, mon_rst[1] falls before edge 1 -> fail_early[1]=1, lat[1]=1, err_cnt=1, err_any=1 after edge 1.
- ch2 start, mon_rst[2] held 1 -> fail_late[2]=1 after edge 3, lat[2]=3. Then clear[2] -> done[2]=0, err_any=0, err_cnt stays 1.
- ch0 and ch3 armed together, both held high -> both fail_late at edge 3, err_cnt increments by 2 in one cycle. Repeat past 255 with ERR_W=8 -> err_cnt holds at 255.
- Abort and precedence cases:
  - rst_n pulsed low mid-WAIT -> all outputs 0 immediately (asynchronous), no verdict.
  - clear in WAIT -> IDLE, no flags.
  - start re-pulsed in WAIT -> verdict still lands at the original edge.
- AUTO_REARM=1, ch0 pass at edge 3 -> done[0] and pass[0] high for one cycle only, lat[0]=3 retained. A new start one cycle later is accepted.

Source files
------------

// File: rtl/rst_window_checker.sv
// Multi-channel reset-release window checker: each armed channel must see its
// monitored reset deassert between MIN_CYC and MAX_CYC edges after arming.
//
// state | meaning
// IDLE  | channel disarmed, waiting for start
// WAIT  | armed, counting edges and sampling mon_rst
// PASS  | deassert landed inside the window
// FAIL  | deassert too early (early_q=1) or never arrived (early_q=0)
module rst_window_checker #(
  parameter int NCH        = 4,
  parameter int MIN_CYC    = 2,
  parameter int MAX_CYC    = 3,
  parameter int CW         = $clog2(MAX_CYC + 1),
  parameter int AUTO_REARM = 0,
  parameter int ERR_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    start,
  input  logic [NCH-1:0]    clear,
  input  logic [NCH-1:0]    mon_rst,
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    done,
  output logic [NCH-1:0]    pass,
  output logic [NCH-1:0]    fail_early,
  output logic [NCH-1:0]    fail_late,
  output logic [NCH*CW-1:0] lat,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              err_any
);

  if (MIN_CYC < 1 || MAX_CYC < MIN_CYC) begin : g_bad_window
    $error("rst_window_checker: need 1 <= MIN_CYC <= MAX_CYC");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PASS, S_FAIL} state_t;

  localparam logic [CW:0]      MIN_K   = (CW+1)'(MIN_CYC);
  localparam logic [CW:0]      MAX_K   = (CW+1)'(MAX_CYC);
  localparam int               NW      = $clog2(NCH + 1);
  localparam int               SW      = ERR_W + NW;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t           state_q [NCH];
  state_t           state_d [NCH];
  logic [CW-1:0]    cnt_q   [NCH];
  logic [CW-1:0]    cnt_d   [NCH];
  logic [CW-1:0]    lat_q   [NCH];
  logic [CW-1:0]    lat_d   [NCH];
  logic [NCH-1:0]   early_q, early_d;
  logic [NCH-1:0]   fail_enter;
  logic [CW:0]      k;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [NW-1:0]    nfail;
  logic [SW-1:0]    err_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
        lat_q[i]   <= '0;
      end
      early_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        lat_q[i]   <= lat_d[i];
      end
      early_q   <= early_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // clear outranks both start and the window evaluation
  always_comb begin
    k          = '0;
    early_d    = early_q;
    fail_enter = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      lat_d[i]   = lat_q[i];
      k          = {1'b0, cnt_q[i]} + (CW+1)'(1);
      case (state_q[i])
        S_IDLE: begin
          if (start[i] && !clear[i]) begin
            state_d[i] = S_WAIT;
            cnt_d[i]   = '0;
            lat_d[i]   = '0;
            early_d[i] = 1'b0;
          end
        end
        S_WAIT: begin
          if (clear[i]) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = k[CW-1:0];
            if (!mon_rst[i]) begin
              lat_d[i] = k[CW-1:0];
              if (k < MIN_K) begin
                state_d[i]    = S_FAIL;
                early_d[i]    = 1'b1;
                fail_enter[i] = 1'b1;
              end else begin
                state_d[i] = S_PASS;
              end
            end else if (k == MAX_K) begin
              state_d[i]    = S_FAIL;
              early_d[i]    = 1'b0;
              lat_d[i]      = MAX_K[CW-1:0];
              fail_enter[i] = 1'b1;
            end
          end
        end
        default: begin
          if (AUTO_REARM != 0 || clear[i]) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
            early_d[i] = 1'b0;
            if (AUTO_REARM == 0) lat_d[i] = '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    nfail = '0;
    for (int i = 0; i < NCH; i++) nfail = nfail + NW'(fail_enter[i]);
    err_sum   = SW'(err_cnt_q) + SW'(nfail);
    err_cnt_d = (err_sum > SW'(ERR_MAX)) ? ERR_MAX : err_sum[ERR_W-1:0];
  end

  always_comb begin
    busy       = '0;
    done       = '0;
    pass       = '0;
    fail_early = '0;
    fail_late  = '0;
    lat        = '0;
    for (int i = 0; i < NCH; i++) begin
      busy[i]          = (state_q[i] == S_WAIT);
      done[i]          = (state_q[i] == S_PASS) || (state_q[i] == S_FAIL);
      pass[i]          = (state_q[i] == S_PASS);
      fail_early[i]    = (state_q[i] == S_FAIL) && early_q[i];
      fail_late[i]     = (state_q[i] == S_FAIL) && !early_q[i];
      lat[i*CW +: CW]  = lat_q[i];
    end
    err_cnt = err_cnt_q;
    err_any = |(fail_early | fail_late);
  end

endmodule

// File: tb/tb_rst_window_checker.sv
// Bench for rst_window_checker: directed window/abort/saturation cases plus a
// randomized run against a timestamp-based model of the window rules.
module tb_rst_window_checker;

  localparam int NCH = 4;
  localparam int MINC = 2;
  localparam int MAXC = 3;
  localparam int CW = 2;
  localparam int ERR_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [NCH-1:0] a_start = '0, a_clear = '0, a_mon = '1;
  logic [NCH-1:0] a_busy, a_done, a_pass, a_fe, a_fl;
  logic [NCH*CW-1:0] a_lat;
  logic [ERR_W-1:0] a_err;
  logic a_any;

  logic [NCH-1:0] b_start = '0, b_clear = '0, b_mon = '1;
  logic [NCH-1:0] b_busy, b_done, b_pass, b_fe, b_fl;
  logic [NCH*CW-1:0] b_lat;
  logic [ERR_W-1:0] b_err;
  logic b_any;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rst_window_checker #(.NCH(NCH), .MIN_CYC(MINC), .MAX_CYC(MAXC), .AUTO_REARM(0), .ERR_W(ERR_W)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .clear(a_clear), .mon_rst(a_mon),
    .busy(a_busy), .done(a_done), .pass(a_pass), .fail_early(a_fe), .fail_late(a_fl),
    .lat(a_lat), .err_cnt(a_err), .err_any(a_any));

  rst_window_checker #(.NCH(NCH), .MIN_CYC(MINC), .MAX_CYC(MAXC), .AUTO_REARM(1), .ERR_W(ERR_W)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .clear(b_clear), .mon_rst(b_mon),
    .busy(b_busy), .done(b_done), .pass(b_pass), .fail_early(b_fe), .fail_late(b_fl),
    .lat(b_lat), .err_cnt(b_err), .err_any(b_any));

  // Reference model: a channel is "armed at edge E"; its age at a later edge
  // is the edge index k, and the verdict follows directly from k and mon_rst.
  int m_arm [NCH];
  bit m_done [NCH];
  bit m_pass [NCH];
  bit m_fe [NCH];
  bit m_fl [NCH];
  int m_lat [NCH];
  int m_err;
  int edge_no;
  bit use_model = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_arm[i] = -1; m_done[i] = 0; m_pass[i] = 0; m_fe[i] = 0; m_fl[i] = 0; m_lat[i] = 0;
    end
    m_err = 0;
    edge_no = 0;
  endtask

  task automatic model_edge();
    int nf;
    int k;
    nf = 0;
    edge_no++;
    for (int i = 0; i < NCH; i++) begin
      if (m_done[i]) begin
        if (a_clear[i]) begin
          m_done[i] = 0; m_pass[i] = 0; m_fe[i] = 0; m_fl[i] = 0; m_lat[i] = 0;
        end
      end else if (m_arm[i] >= 0) begin
        if (a_clear[i]) m_arm[i] = -1;
        else begin
          k = edge_no - m_arm[i];
          if (!a_mon[i]) begin
            m_done[i] = 1; m_lat[i] = k; m_arm[i] = -1;
            if (k < MINC) begin m_fe[i] = 1; nf++; end
            else m_pass[i] = 1;
          end else if (k >= MAXC) begin
            m_done[i] = 1; m_fl[i] = 1; m_lat[i] = MAXC; m_arm[i] = -1; nf++;
          end
        end
      end else if (a_start[i] && !a_clear[i]) begin
        m_arm[i] = edge_no;
        m_lat[i] = 0;
      end
    end
    m_err = (m_err + nf > 255) ? 255 : m_err + nf;
  endtask

  task automatic tick();
    @(posedge clk);
    if (use_model) model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_start = '0; a_clear = '0; a_mon = '1;
    b_start = '0; b_clear = '0; b_mon = '1;
    tick();
    tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({a_busy, a_done, a_pass, a_fe, a_fl, a_lat, a_err, a_any} !== '0) begin
      errors++; $display("FAIL reset_a: got busy=%b done=%b lat=%h err=%0d any=%b want all 0", a_busy, a_done, a_lat, a_err, a_any);
    end
    checks++;
    if ({b_busy, b_done, b_pass, b_fe, b_fl, b_lat, b_err, b_any} !== '0) begin
      errors++; $display("FAIL reset_b: got busy=%b done=%b lat=%h err=%0d want all 0", b_busy, b_done, b_lat, b_err);
    end
    do_reset();
  endtask

  task automatic test_pass();
    do_reset();
    a_start = 4'b0001; tick();
    checks++; if (a_busy !== 4'b0001) begin errors++; $display("FAIL pass_arm_busy: got %b want 0001", a_busy); end
    a_start = '0; tick();
    checks++; if (a_done !== 4'b0000) begin errors++; $display("FAIL pass_e1_done: got %b want 0000", a_done); end
    a_mon[0] = 1'b0; tick();
    checks++; if (a_pass !== 4'b0001 || a_done !== 4'b0001) begin errors++; $display("FAIL pass_e2: got pass=%b done=%b want 0001", a_pass, a_done); end
    checks++; if (a_lat[1:0] !== 2'd2) begin errors++; $display("FAIL pass_lat: got %0d want 2", a_lat[1:0]); end
    checks++; if (a_err !== 8'd0 || a_busy !== 4'b0000 || a_any !== 1'b0) begin errors++; $display("FAIL pass_misc: got err=%0d busy=%b any=%b want 0", a_err, a_busy, a_any); end
    a_mon = '1; a_clear = 4'b0001; tick(); a_clear = '0;
    checks++; if (a_done !== 4'b0000 || a_lat !== 8'h00) begin errors++; $display("FAIL pass_clear: got done=%b lat=%h want 0", a_done, a_lat); end
    // deassert already present at the arming edge must not count
    a_mon[0] = 1'b0; a_start = 4'b0001; tick();
    a_start = '0; a_mon[0] = 1'b1; tick();
    checks++; if (a_busy[0] !== 1'b1 || a_done[0] !== 1'b0) begin errors++; $display("FAIL arm_edge_ignored: got busy=%b done=%b want 1 0", a_busy[0], a_done[0]); end
    a_mon[0] = 1'b0; tick();
    checks++; if (a_pass[0] !== 1'b1 || a_lat[1:0] !== 2'd2) begin errors++; $display("FAIL arm_edge_pass: got pass=%b lat=%0d want 1 2", a_pass[0], a_lat[1:0]); end
    a_mon = '1; a_clear = 4'b0001; tick(); a_clear = '0;
  endtask

  task automatic test_fail_early();
    a_start = 4'b0010; tick();
    a_start = '0; a_mon[1] = 1'b0; tick();
    checks++; if (a_fe !== 4'b0010 || a_fl !== 4'b0000) begin errors++; $display("FAIL early_flags: got fe=%b fl=%b want 0010 0000", a_fe, a_fl); end
    checks++; if (a_lat[3:2] !== 2'd1 || a_err !== 8'd1 || a_any !== 1'b1) begin errors++; $display("FAIL early_lat_err: got lat=%0d err=%0d any=%b want 1 1 1", a_lat[3:2], a_err, a_any); end
    a_mon = '1; a_clear = 4'b0010; tick(); a_clear = '0;
  endtask

  task automatic test_fail_late();
    do_reset();
    a_start = 4'b0100; tick();
    a_start = '0; tick(); tick();
    checks++; if (a_done !== 4'b0000 || a_busy !== 4'b0100) begin errors++; $display("FAIL late_e2: got done=%b busy=%b want 0000 0100", a_done, a_busy); end
    tick();
    checks++; if (a_fl !== 4'b0100 || a_lat[5:4] !== 2'd3 || a_err !== 8'd1) begin errors++; $display("FAIL late_e3: got fl=%b lat=%0d err=%0d want 0100 3 1", a_fl, a_lat[5:4], a_err); end
    a_clear = 4'b0100; tick(); a_clear = '0;
    checks++; if (a_done !== 4'b0000 || a_any !== 1'b0 || a_err !== 8'd1) begin errors++; $display("FAIL late_clear: got done=%b any=%b err=%0d want 0000 0 1", a_done, a_any, a_err); end
  endtask

  task automatic test_dual_saturate();
    int exp;
    do_reset();
    a_start = 4'b1001; tick();
    a_start = '0; tick(); tick();
    checks++; if (a_err !== 8'd0) begin errors++; $display("FAIL dual_e2_err: got %0d want 0", a_err); end
    tick();
    checks++; if (a_fl !== 4'b1001 || a_err !== 8'd2) begin errors++; $display("FAIL dual_e3: got fl=%b err=%0d want 1001 2", a_fl, a_err); end
    for (int r = 1; r <= 70; r++) begin
      a_clear = '1; tick();
      a_clear = '0; a_start = '1; tick();
      a_start = '0; tick(); tick(); tick();
      exp = (2 + 4 * r > 255) ? 255 : 2 + 4 * r;
      checks++; if (a_err !== exp[7:0]) begin errors++; $display("FAIL sat_round%0d: got %0d want %0d", r, a_err, exp); end
    end
  endtask

  task automatic test_abort();
    do_reset();
    a_start = 4'b0001; tick();
    a_start = '0; tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({a_busy, a_done, a_lat, a_err, a_any} !== '0) begin errors++; $display("FAIL async_reset: got busy=%b done=%b err=%0d want 0", a_busy, a_done, a_err); end
    @(negedge clk); rst_n = 1'b1;
    tick(); tick(); tick(); tick();
    checks++; if (a_done !== 4'b0000 || a_busy !== 4'b0000 || a_err !== 8'd0) begin errors++; $display("FAIL reset_no_verdict: got done=%b busy=%b err=%0d want 0", a_done, a_busy, a_err); end
    a_start = 4'b0010; tick();
    a_start = '0; tick();
    a_clear = 4'b0010; tick(); a_clear = '0;
    checks++; if (a_busy !== 4'b0000 || a_done !== 4'b0000) begin errors++; $display("FAIL clear_wait: got busy=%b done=%b want 0", a_busy, a_done); end
    tick(); tick();
    checks++; if (a_done !== 4'b0000 || a_err !== 8'd0) begin errors++; $display("FAIL clear_wait_later: got done=%b err=%0d want 0", a_done, a_err); end
    a_start = 4'b0100; a_clear = 4'b0100; tick();
    a_start = '0; a_clear = '0;
    checks++; if (a_busy[2] !== 1'b0) begin errors++; $display("FAIL clear_beats_start: got busy=%b want 0", a_busy[2]); end
    a_start = 4'b0100; tick(); a_start = '0;
    checks++; if (a_busy[2] !== 1'b1) begin errors++; $display("FAIL later_start: got busy=%b want 1", a_busy[2]); end
    a_clear = 4'b0100; tick(); a_clear = '0;
    a_start = 4'b1000; tick();
    a_start = '0; tick();
    a_start = 4'b1000; tick(); a_start = '0;
    checks++; if (a_busy[3] !== 1'b1 || a_done[3] !== 1'b0) begin errors++; $display("FAIL restart_e2: got busy=%b done=%b want 1 0", a_busy[3], a_done[3]); end
    tick();
    checks++; if (a_fl[3] !== 1'b1 || a_lat[7:6] !== 2'd3) begin errors++; $display("FAIL restart_e3: got fl=%b lat=%0d want 1 3", a_fl[3], a_lat[7:6]); end
  endtask

  task automatic test_random();
    logic [NCH-1:0] e_busy, e_done, e_pass, e_fe, e_fl;
    logic [NCH*CW-1:0] e_lat;
    do_reset();
    use_model = 1'b1;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NCH; i++) begin
        a_start[i] = ($urandom_range(0, 2) == 0);
        a_clear[i] = ($urandom_range(0, 7) == 0);
        a_mon[i]   = ($urandom_range(0, 2) != 0);
      end
      tick();
      for (int i = 0; i < NCH; i++) begin
        e_busy[i] = (m_arm[i] >= 0);
        e_done[i] = m_done[i];
        e_pass[i] = m_pass[i];
        e_fe[i] = m_fe[i];
        e_fl[i] = m_fl[i];
        e_lat[i*CW +: CW] = m_lat[i][1:0];
      end
      checks++; if (a_busy !== e_busy || a_done !== e_done) begin errors++; $display("FAIL rnd%0d_busy_done: got %b %b want %b %b", c, a_busy, a_done, e_busy, e_done); end
      checks++; if (a_pass !== e_pass || a_fe !== e_fe || a_fl !== e_fl) begin errors++; $display("FAIL rnd%0d_flags: got p=%b fe=%b fl=%b want p=%b fe=%b fl=%b", c, a_pass, a_fe, a_fl, e_pass, e_fe, e_fl); end
      checks++; if (a_lat !== e_lat) begin errors++; $display("FAIL rnd%0d_lat: got %h want %h", c, a_lat, e_lat); end
      checks++; if (a_err !== m_err[7:0] || a_any !== |(e_fe | e_fl)) begin errors++; $display("FAIL rnd%0d_err: got err=%0d any=%b want %0d %b", c, a_err, a_any, m_err, |(e_fe | e_fl)); end
    end
    use_model = 1'b0;
  endtask

  task automatic test_auto_rearm();
    do_reset();
    b_start = 4'b0001; tick();
    b_start = '0; tick(); tick();
    b_mon[0] = 1'b0; tick();
    checks++; if (b_done !== 4'b0001 || b_pass !== 4'b0001 || b_lat[1:0] !== 2'd3 || b_busy !== 4'b0000) begin
      errors++; $display("FAIL ar_pass: got done=%b pass=%b lat=%0d busy=%b want 0001 0001 3 0000", b_done, b_pass, b_lat[1:0], b_busy);
    end
    b_mon = '1; tick();
    checks++; if (b_done !== 4'b0000 || b_pass !== 4'b0000 || b_lat[1:0] !== 2'd3 || b_busy !== 4'b0000) begin
      errors++; $display("FAIL ar_pulse_end: got done=%b pass=%b lat=%0d busy=%b want 0000 0000 3 0000", b_done, b_pass, b_lat[1:0], b_busy);
    end
    b_start = 4'b0001; tick(); b_start = '0;
    checks++; if (b_busy[0] !== 1'b1) begin errors++; $display("FAIL ar_rearm: got busy=%b want 1", b_busy[0]); end
    b_start = 4'b0010; b_clear = 4'b0001; tick();
    b_start = '0; b_clear = '0; b_mon[1] = 1'b0; tick();
    checks++; if (b_fe !== 4'b0010 || b_any !== 1'b1 || b_err !== 8'd1) begin errors++; $display("FAIL ar_fail: got fe=%b any=%b err=%0d want 0010 1 1", b_fe, b_any, b_err); end
    b_mon = '1; tick();
    checks++; if (b_fe !== 4'b0000 || b_any !== 1'b0 || b_err !== 8'd1 || b_lat[3:2] !== 2'd1) begin
      errors++; $display("FAIL ar_fail_end: got fe=%b any=%b err=%0d lat=%0d want 0000 0 1 1", b_fe, b_any, b_err, b_lat[3:2]);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail_early();
    test_fail_late();
    test_dual_saturate();
    test_abort();
    test_random();
    test_auto_rearm();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
